gsm_ingress_alloc: RTL and testbench

Ingress-side writer for the grouped-shared-memory switch. It accepts cells from one input link and allocates a free cell address from an on-chip free-address list. It then drives the shared memory's write port (write enable, address, data, multicast vector). Addresses that the shared memory reports as free (buffer-free pulse and address) are returned to the list, closing the allocation loop.

---
 rtl/gsm_ingress_alloc.sv | 107 ++++++++++
 tb/tb_gsm_ingress_alloc.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gsm_ingress_alloc.sv
// Ingress writer for the grouped-shared-memory switch: allocates free cell
// addresses from a circular free list and drives the shared-memory write port.
module gsm_ingress_alloc #(
    parameter int unsigned MWIDTH = 4,
    parameter int unsigned DWIDTH = 128,
    parameter int unsigned AWIDTH = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_cell_valid,
    input  logic [DWIDTH-1:0] i_cell_data,
    input  logic [MWIDTH-1:0] i_cell_multicast,
    output logic              o_cell_ready,
    output logic              o_wr_en,
    output logic [AWIDTH-1:0] o_wr_addr,
    output logic [DWIDTH-1:0] o_wr_data,
    output logic [MWIDTH-1:0] o_multicast,
    input  logic              i_buf_free,
    input  logic [AWIDTH-1:0] i_buf_free_addr,
    output logic [AWIDTH:0]   o_free_cnt,
    output logic              o_init_done,
    output logic              o_drop,
    output logic              o_err
);

    localparam int unsigned DEPTH = 1 << AWIDTH;
    localparam logic [AWIDTH:0] FULL = {1'b1, {AWIDTH{1'b0}}};

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t state, state_next;

    logic [AWIDTH-1:0] mem [DEPTH];
    logic [AWIDTH-1:0] init_cnt;
    logic [AWIDTH-1:0] rd_ptr;
    logic [AWIDTH-1:0] wr_ptr;
    logic              accept;
    logic              pop;
    logic              push;
    logic              dbl_free;
    logic              init_last;

    assign o_init_done  = (state == ST_RUN);
    assign o_cell_ready = (state == ST_RUN) && (o_free_cnt != '0);
    assign accept       = i_cell_valid && o_cell_ready;
    assign pop          = accept && (i_cell_multicast != '0);
    // A return at a full list is only legal when a pop frees a slot that cycle.
    assign dbl_free     = (state == ST_RUN) && i_buf_free && (o_free_cnt == FULL) && !pop;
    assign push         = (state == ST_RUN) && i_buf_free && !dbl_free;
    assign init_last    = (state == ST_INIT) && (init_cnt == '1);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_INIT;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_INIT: if (init_last) state_next = ST_RUN;
            ST_RUN:  state_next = ST_RUN;
            default: state_next = ST_INIT;
        endcase
    end

    // Asynchronous-read storage: the head address is usable in the accept cycle.
    always_ff @(posedge clk) begin
        if (state == ST_INIT)
            mem[init_cnt] <= init_cnt;
        else if (push)
            mem[wr_ptr] <= i_buf_free_addr;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            init_cnt    <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            o_free_cnt  <= '0;
            o_wr_en     <= 1'b0;
            o_wr_addr   <= '0;
            o_wr_data   <= '0;
            o_multicast <= '0;
            o_drop      <= 1'b0;
            o_err       <= 1'b0;
        end else begin
            o_wr_en <= pop;
            o_drop  <= accept && (i_cell_multicast == '0);
            o_err   <= dbl_free;
            if (state == ST_INIT) begin
                init_cnt <= init_cnt + 1'b1;
                if (init_last) o_free_cnt <= FULL;
            end else begin
                if (pop) begin
                    rd_ptr      <= rd_ptr + 1'b1;
                    o_wr_addr   <= mem[rd_ptr];
                    o_wr_data   <= i_cell_data;
                    o_multicast <= i_cell_multicast;
                end
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (push && !pop)      o_free_cnt <= o_free_cnt + 1'b1;
                else if (pop && !push) o_free_cnt <= o_free_cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_gsm_ingress_alloc.sv
// Scoreboard bench for gsm_ingress_alloc: a queue model of the free list
// predicts write addresses, pulses and the free count every cycle.
module tb_gsm_ingress_alloc;

    logic         clk;
    logic         rst_n;
    logic         cell_valid;
    logic [127:0] cell_data;
    logic [3:0]   cell_mc;
    logic         cell_ready;
    logic         wr_en;
    logic [8:0]   wr_addr;
    logic [127:0] wr_data;
    logic [3:0]   wr_mc;
    logic         buf_free;
    logic [8:0]   buf_free_addr;
    logic [9:0]   free_cnt;
    logic         init_done;
    logic         drop;
    logic         err;

    typedef struct {
        logic [8:0]   a;
        logic [127:0] d;
        logic [3:0]   m;
    } wr_t;

    wr_t        sb[$];
    logic [8:0] free_q[$];
    logic [8:0] held[$];
    int         checks = 0;
    int         errors = 0;

    gsm_ingress_alloc #(.MWIDTH(4), .DWIDTH(128), .AWIDTH(9)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .i_cell_valid(cell_valid),
        .i_cell_data(cell_data),
        .i_cell_multicast(cell_mc),
        .o_cell_ready(cell_ready),
        .o_wr_en(wr_en),
        .o_wr_addr(wr_addr),
        .o_wr_data(wr_data),
        .o_multicast(wr_mc),
        .i_buf_free(buf_free),
        .i_buf_free_addr(buf_free_addr),
        .o_free_cnt(free_cnt),
        .o_init_done(init_done),
        .o_drop(drop),
        .o_err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write-port monitor: every strobe must match the oldest predicted write.
    always @(posedge clk) begin
        #1;
        if (wr_en === 1'b1) begin
            wr_t e;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL wr_unexpected addr=%0d", wr_addr);
            end else begin
                e = sb.pop_front();
                if (wr_addr !== e.a || wr_data !== e.d || wr_mc !== e.m) begin
                    errors++;
                    $display("FAIL wr_port got a=%0d m=%b d=%h want a=%0d m=%b d=%h",
                             wr_addr, wr_mc, wr_data, e.a, e.m, e.d);
                end
            end
        end
    end

    task automatic model_fill();
        free_q.delete();
        sb.delete();
        for (int unsigned i = 0; i < 512; i++) free_q.push_back(9'(i));
    endtask

    task automatic cycle(input logic v, input logic [3:0] mc, input logic fr,
                         input logic [8:0] fa, output logic [8:0] got);
        logic [127:0] d;
        logic acc, pop, e_drop, e_err;
        @(negedge clk);
        d = {$urandom, $urandom, $urandom, $urandom};
        cell_valid    = v;
        cell_data     = d;
        cell_mc       = mc;
        buf_free      = fr;
        buf_free_addr = fa;
        acc    = v && (free_q.size() != 0);
        pop    = acc && (mc != 4'd0);
        e_drop = acc && (mc == 4'd0);
        e_err  = fr && (free_q.size() == 512) && !pop;
        got    = '0;
        if (pop) begin
            got = free_q.pop_front();
            sb.push_back('{a: got, d: d, m: mc});
        end
        if (fr && !e_err) free_q.push_back(fa);
        @(posedge clk);
        #1;
        checks += 5;
        if (wr_en !== pop) begin
            errors++; $display("FAIL wr_en got %b want %b", wr_en, pop);
        end
        if (drop !== e_drop) begin
            errors++; $display("FAIL drop got %b want %b", drop, e_drop);
        end
        if (err !== e_err) begin
            errors++; $display("FAIL err got %b want %b", err, e_err);
        end
        if (free_cnt !== 10'(free_q.size())) begin
            errors++; $display("FAIL free_cnt got %0d want %0d", free_cnt, free_q.size());
        end
        if (cell_ready !== (free_q.size() != 0)) begin
            errors++; $display("FAIL ready got %b want %b", cell_ready, free_q.size() != 0);
        end
    endtask

    task automatic idle();
        logic [8:0] g;
        cycle(1'b0, 4'd0, 1'b0, 9'd0, g);
    endtask

    task automatic init_wait();
        int n = 0;
        while (init_done !== 1'b1 && n < 600) begin
            @(posedge clk);
            #1;
            n++;
            if (init_done !== 1'b1) begin
                checks++;
                if (cell_ready !== 1'b0) begin
                    errors++; $display("FAIL init_ready cycle %0d got %b want 0", n, cell_ready);
                end
            end
        end
        checks += 3;
        if (n != 512) begin
            errors++; $display("FAIL init_cycles got %0d want 512", n);
        end
        if (free_cnt !== 10'd512) begin
            errors++; $display("FAIL init_cnt got %0d want 512", free_cnt);
        end
        if (cell_ready !== 1'b1) begin
            errors++; $display("FAIL init_rdy got %b want 1", cell_ready);
        end
    endtask

    task automatic check_zero(input string tag);
        checks++;
        if ({cell_ready, wr_en, wr_addr, wr_data, wr_mc, free_cnt, init_done, drop, err} !== '0) begin
            errors++;
            $display("FAIL %s outputs rdy=%b we=%b a=%0d m=%b cnt=%0d done=%b drop=%b err=%b want all 0",
                     tag, cell_ready, wr_en, wr_addr, wr_mc, free_cnt, init_done, drop, err);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        init_wait();
        model_fill();
    endtask

    task automatic test_alloc_order();
        logic [8:0] g;
        for (int i = 0; i < 3; i++) cycle(1'b1, 4'b0101, 1'b0, 9'd0, g);
        idle();
        checks++;
        if (free_cnt !== 10'd509) begin
            errors++; $display("FAIL order_cnt got %0d want 509", free_cnt);
        end
    endtask

    task automatic test_drop_err();
        logic [8:0] g;
        for (int i = 0; i < 3; i++) cycle(1'b0, 4'd0, 1'b1, 9'(i), g);
        cycle(1'b0, 4'd0, 1'b1, 9'd0, g);
        checks++;
        if (err !== 1'b1 || free_cnt !== 10'd512) begin
            errors++; $display("FAIL dbl_free got err=%b cnt=%0d want 1 512", err, free_cnt);
        end
        cycle(1'b1, 4'd0, 1'b0, 9'd0, g);
        checks++;
        if (drop !== 1'b1 || wr_en !== 1'b0 || free_cnt !== 10'd512) begin
            errors++; $display("FAIL drop_cell got drop=%b we=%b cnt=%0d want 1 0 512", drop, wr_en, free_cnt);
        end
        idle();
    endtask

    task automatic test_exhaust();
        logic [8:0] g;
        for (int i = 0; i < 512; i++) cycle(1'b1, 4'(1 + (i % 15)), 1'b0, 9'd0, g);
        checks++;
        if (free_cnt !== 10'd0 || cell_ready !== 1'b0) begin
            errors++; $display("FAIL empty got cnt=%0d rdy=%b want 0 0", free_cnt, cell_ready);
        end
        cycle(1'b1, 4'b1000, 1'b0, 9'd0, g);
        cycle(1'b1, 4'b1000, 1'b1, 9'd5, g);
        checks++;
        if (free_cnt !== 10'd1 || cell_ready !== 1'b1) begin
            errors++; $display("FAIL recycle got cnt=%0d rdy=%b want 1 1", free_cnt, cell_ready);
        end
        cycle(1'b1, 4'b1000, 1'b0, 9'd0, g);
        checks++;
        if (wr_en !== 1'b1 || wr_addr !== 9'd5) begin
            errors++; $display("FAIL recycle_addr got we=%b a=%0d want 1 5", wr_en, wr_addr);
        end
    endtask

    task automatic test_simultaneous();
        logic [8:0] g;
        for (int i = 10; i < 110; i++) cycle(1'b0, 4'd0, 1'b1, 9'(i), g);
        cycle(1'b1, 4'b0011, 1'b1, 9'd7, g);
        checks++;
        if (free_cnt !== 10'd100 || wr_en !== 1'b1) begin
            errors++; $display("FAIL simul got cnt=%0d we=%b want 100 1", free_cnt, wr_en);
        end
    endtask

    task automatic test_wrap();
        logic [8:0] g;
        logic [8:0] fa;
        logic       fr;
        held.delete();
        for (int i = 0; i < 1000; i++) begin
            fr = (i >= 50);
            fa = fr ? held.pop_front() : 9'd0;
            cycle(1'b1, 4'($urandom_range(1, 15)), fr, fa, g);
            held.push_back(g);
        end
        while (held.size() != 0) cycle(1'b0, 4'd0, 1'b1, held.pop_front(), g);
        checks++;
        if (free_cnt !== 10'd100) begin
            errors++; $display("FAIL wrap_cnt got %0d want 100", free_cnt);
        end
    endtask

    task automatic test_mid_reset();
        logic [8:0] g;
        for (int i = 200; i < 300; i++) cycle(1'b0, 4'd0, 1'b1, 9'(i), g);
        checks++;
        if (free_cnt !== 10'd200) begin
            errors++; $display("FAIL pre_reset_cnt got %0d want 200", free_cnt);
        end
        @(negedge clk);
        rst_n         = 1'b0;
        cell_valid    = 1'b1;
        cell_mc       = 4'b1111;
        cell_data     = {4{32'hdead_beef}};
        buf_free      = 1'b0;
        @(posedge clk);
        #1;
        check_zero("mid_reset");
        @(negedge clk);
        cell_valid = 1'b0;
        rst_n      = 1'b1;
        init_wait();
        model_fill();
        cycle(1'b1, 4'b0011, 1'b0, 9'd0, g);
        checks++;
        if (wr_en !== 1'b1 || wr_addr !== 9'd0) begin
            errors++; $display("FAIL reinit_addr got we=%b a=%0d want 1 0", wr_en, wr_addr);
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        cell_valid    = 1'b0;
        cell_data     = '0;
        cell_mc       = '0;
        buf_free      = 1'b0;
        buf_free_addr = '0;
        test_reset();
        test_alloc_order();
        test_drop_err();
        test_exhaust();
        test_simultaneous();
        test_wrap();
        test_mid_reset();
        repeat (3) idle();
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL sb_drain got %0d pending want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
